// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I core: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and unified memory, with optional wait-states and illegal-opcode trapping.
//
// state      | meaning
// FETCH      | read instruction, PC <= PC+4 on mem_ready
// DECODE     | branch target into ALUOut, dispatch on op
// MEMADR     | rs1+imm into ALUOut
// MEMREAD    | data read, held until mem_ready
// MEMWB      | load data to rd
// MEMWRITE   | data write, held until mem_ready
// EXECR      | R-type ALU operation
// EXECI      | I-type ALU operation
// ALUWB      | ALUOut to rd
// BRANCH     | compare rs1/rs2, PC <= ALUOut if taken
// JAL        | PC <= target, link OldPC+4
// JALR       | rs1+imm into ALUOut
// JALRPC     | PC <= ALUOut, link OldPC+4
// UPPER      | lui / auipc
// TRAP       | illegal instruction, held until reset
module multicycle_controller #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit ILLEGAL_TRAP  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       adr_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic [2:0] imm_src,
  output logic [1:0] store,
  output logic [2:0] load,
  output logic       retire,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
    S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALRPC, S_UPPER, S_TRAP
  } state_t;

  state_t     state, state_next;
  logic [2:0] f3_q;
  logic       is_store_q, is_lui_q;
  logic       ready, legal, taken, pc_update;
  state_t     dispatch;
  logic [2:0] load_dec;
  logic [1:0] store_dec;

  assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

  // funct3 and the load/store/lui distinction are captured in DECODE and held for the
  // rest of the instruction, so width outputs stay stable through the memory states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_FETCH;
      f3_q       <= 3'b000;
      is_store_q <= 1'b0;
      is_lui_q   <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_DECODE) begin
        f3_q       <= funct3;
        is_store_q <= op[5];
        is_lui_q   <= op[5];
      end
    end
  end

  always_comb begin
    dispatch = S_TRAP;
    legal    = 1'b1;
    case (op)
      7'b0000011: begin
        dispatch = S_MEMADR;
        legal    = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
      end
      7'b0100011: begin
        dispatch = S_MEMADR;
        legal    = (funct3 < 3'b011);
      end
      7'b0110011: dispatch = S_EXECR;
      7'b0010011: dispatch = S_EXECI;
      7'b1100011: begin
        dispatch = S_BRANCH;
        legal    = (funct3 != 3'b010) && (funct3 != 3'b011);
      end
      7'b1101111: dispatch = S_JAL;
      7'b1100111: dispatch = S_JALR;
      7'b0110111, 7'b0010111: dispatch = S_UPPER;
      default: legal = 1'b0;
    endcase

    case (f3_q)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      3'b110:  taken = ltu;
      3'b111:  taken = !ltu;
      default: taken = 1'b0;
    endcase

    case (f3_q)
      3'b001:  load_dec = 3'b001;
      3'b010:  load_dec = 3'b010;
      3'b100:  load_dec = 3'b011;
      3'b101:  load_dec = 3'b100;
      default: load_dec = 3'b000;
    endcase

    case (f3_q)
      3'b000:  store_dec = 2'b10;
      3'b001:  store_dec = 2'b01;
      default: store_dec = 2'b00;
    endcase
  end

  always_comb begin
    state_next = state;
    pc_update  = 1'b0;
    mem_req    = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    imm_src    = 3'b000;
    store      = 2'b00;
    load       = 3'b000;
    retire     = 1'b0;
    illegal    = 1'b0;
    // Outputs are forced low for as long as reset is held, even mid-access.
    if (!reset) begin
      case (state)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          ir_write   = ready;
          pc_update  = ready;
          if (ready) state_next = S_DECODE;
        end
        S_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
          imm_src   = 3'b010;
          if (legal)             state_next = dispatch;
          else if (ILLEGAL_TRAP) state_next = S_TRAP;
          else begin
            retire     = 1'b1;
            state_next = S_FETCH;
          end
        end
        S_MEMADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          if (is_store_q) begin
            imm_src    = 3'b001;
            store      = store_dec;
            state_next = S_MEMWRITE;
          end else begin
            load       = load_dec;
            state_next = S_MEMREAD;
          end
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
          load    = load_dec;
          if (ready) state_next = S_MEMWB;
        end
        S_MEMWB: begin
          result_src = 2'b01;
          reg_write  = 1'b1;
          retire     = 1'b1;
          load       = load_dec;
          state_next = S_FETCH;
        end
        S_MEMWRITE: begin
          mem_req   = 1'b1;
          adr_src   = 1'b1;
          mem_write = 1'b1;
          store     = store_dec;
          retire    = ready;
          if (ready) state_next = S_FETCH;
        end
        S_EXECR: begin
          alu_src_a  = 2'b10;
          alu_op     = 2'b10;
          state_next = S_ALUWB;
        end
        S_EXECI: begin
          alu_src_a  = 2'b10;
          alu_src_b  = 2'b01;
          alu_op     = 2'b10;
          state_next = S_ALUWB;
        end
        S_ALUWB: begin
          reg_write  = 1'b1;
          retire     = 1'b1;
          state_next = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a  = 2'b10;
          alu_op     = 2'b01;
          retire     = 1'b1;
          pc_write   = taken;
          state_next = S_FETCH;
        end
        S_JAL: begin
          alu_src_a  = 2'b01;
          alu_src_b  = 2'b10;
          imm_src    = 3'b011;
          pc_update  = 1'b1;
          state_next = S_ALUWB;
        end
        S_JALR: begin
          alu_src_a  = 2'b10;
          alu_src_b  = 2'b01;
          state_next = S_JALRPC;
        end
        S_JALRPC: begin
          alu_src_a  = 2'b01;
          alu_src_b  = 2'b10;
          pc_update  = 1'b1;
          state_next = S_ALUWB;
        end
        S_UPPER: begin
          imm_src    = 3'b100;
          alu_src_b  = 2'b01;
          alu_src_a  = is_lui_q ? 2'b11 : 2'b01;
          state_next = S_ALUWB;
        end
        S_TRAP: illegal = 1'b1;
        default: state_next = S_FETCH;
      endcase
      if (pc_update) pc_write = 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-instruction expectations are queued by the
// stimulus and checked by a monitor on every retire pulse; trap/reset cases are checked inline.
module tb_multicycle_controller;

  logic       clk, reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero, lt, ltu, mem_ready;
  logic       mem_req, pc_write, ir_write, reg_write, mem_write, adr_src, retire, illegal;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src, store;
  logic [2:0] imm_src, load;

  logic       nt_ready;
  logic       nt_mem_req, nt_pc_write, nt_ir_write, nt_reg_write, nt_mem_write, nt_adr_src;
  logic       nt_retire, nt_illegal;
  logic [1:0] nt_alu_src_a, nt_alu_src_b, nt_alu_op, nt_result_src, nt_store;
  logic [2:0] nt_imm_src, nt_load;

  multicycle_controller #(.MEM_HANDSHAKE(1'b1), .ILLEGAL_TRAP(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .zero(zero), .lt(lt), .ltu(ltu),
    .mem_ready(mem_ready), .mem_req(mem_req), .pc_write(pc_write), .ir_write(ir_write),
    .reg_write(reg_write), .mem_write(mem_write), .adr_src(adr_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src), .imm_src(imm_src),
    .store(store), .load(load), .retire(retire), .illegal(illegal));

  multicycle_controller #(.MEM_HANDSHAKE(1'b1), .ILLEGAL_TRAP(1'b0)) dut_nt (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .zero(zero), .lt(lt), .ltu(ltu),
    .mem_ready(nt_ready), .mem_req(nt_mem_req), .pc_write(nt_pc_write), .ir_write(nt_ir_write),
    .reg_write(nt_reg_write), .mem_write(nt_mem_write), .adr_src(nt_adr_src),
    .alu_src_a(nt_alu_src_a), .alu_src_b(nt_alu_src_b), .alu_op(nt_alu_op),
    .result_src(nt_result_src), .imm_src(nt_imm_src), .store(nt_store), .load(nt_load),
    .retire(nt_retire), .illegal(nt_illegal));

  typedef struct {
    string name;
    int cycles, rw, mw, pcw, irw, mreq, rw_cyc, ld, st;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0, passed = 0, done_cnt = 0;
  int   wait_left = 0;
  logic hold_fetch = 1'b0;
  int   cyc, n_rw, n_mw, n_pcw, n_irw, n_mreq, rw_cyc, ld_seen, st_seen;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void check(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  // Memory responder: inserts wait_left wait-states into data accesses.
  always @(negedge clk) begin
    if (hold_fetch) mem_ready = 1'b0;
    else if (mem_req && adr_src && wait_left > 0) begin
      mem_ready = 1'b0;
      wait_left = wait_left - 1;
    end else mem_ready = 1'b1;
  end

  function automatic void clear_acc();
    cyc = 0; n_rw = 0; n_mw = 0; n_pcw = 0; n_irw = 0; n_mreq = 0;
    rw_cyc = 0; ld_seen = 0; st_seen = 0;
  endfunction

  initial begin
    exp_t e;
    clear_acc();
    forever begin
      @(negedge clk);
      #2;
      if (reset || hold_fetch) clear_acc();
      else begin
        cyc++;
        n_rw   += int'(reg_write);
        n_mw   += int'(mem_write);
        n_pcw  += int'(pc_write);
        n_irw  += int'(ir_write);
        n_mreq += int'(mem_req);
        if (reg_write && rw_cyc == 0) rw_cyc = cyc;
        if (reg_write && result_src == 2'b01) ld_seen = int'(load);
        if (mem_write) st_seen = int'(store);
        if (retire) begin
          if (sb_q.size() == 0) check("unexpected_retire", 1, 0);
          else begin
            e = sb_q.pop_front();
            check({e.name, "_cycles"}, cyc, e.cycles);
            check({e.name, "_reg_write"}, n_rw, e.rw);
            check({e.name, "_mem_write"}, n_mw, e.mw);
            check({e.name, "_pc_write"}, n_pcw, e.pcw);
            check({e.name, "_ir_write"}, n_irw, e.irw);
            check({e.name, "_mem_req"}, n_mreq, e.mreq);
            check({e.name, "_rw_cycle"}, rw_cyc, e.rw_cyc);
            check({e.name, "_load"}, ld_seen, e.ld);
            check({e.name, "_store"}, st_seen, e.st);
          end
          clear_acc();
          done_cnt++;
        end
      end
    end
  end

  task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                           input logic z, input logic l, input logic lu, input int ws,
                           input int cycles, input int rw, input int mw, input int pcw,
                           input int mreq, input int rwc, input int ld, input int st);
    exp_t e;
    int start;
    e.name = name; e.cycles = cycles; e.rw = rw; e.mw = mw; e.pcw = pcw; e.irw = 1;
    e.mreq = mreq; e.rw_cyc = rwc; e.ld = ld; e.st = st;
    sb_q.push_back(e);
    op = o; funct3 = f3; zero = z; lt = l; ltu = lu; wait_left = ws;
    start = done_cnt;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #3;
      if (done_cnt != start) break;
    end
    check({name, "_retired"}, done_cnt - start, 1);
  endtask

  task automatic reset_cycle();
    @(negedge clk);
    #3;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    int n_ill, n_wr, n_ret, nt_ret, nt_ill, nt_data;
    bit seen;
    reset = 1'b1; op = 7'b0110011; funct3 = 3'b000; zero = 1'b0; lt = 1'b0; ltu = 1'b0;
    mem_ready = 1'b1; nt_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs", int'(|{mem_req, pc_write, ir_write, reg_write, mem_write, adr_src,
          alu_src_a, alu_src_b, alu_op, result_src, imm_src, store, load, retire, illegal}), 0);
    @(posedge clk);
    #2;
    reset = 1'b0;

    //        name     op          f3      z     l     lu  ws cyc rw mw pcw mreq rwc ld st
    run_instr("add",   7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 0, 4, 1, 0, 1, 1, 4, 0, 0);
    run_instr("addi",  7'b0010011, 3'b000, 1'b0, 1'b0, 1'b0, 0, 4, 1, 0, 1, 1, 4, 0, 0);
    run_instr("lw_w2", 7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 2, 7, 1, 0, 1, 4, 7, 2, 0);
    run_instr("lw",    7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 0, 5, 1, 0, 1, 2, 5, 2, 0);
    run_instr("lbu",   7'b0000011, 3'b100, 1'b0, 1'b0, 1'b0, 0, 5, 1, 0, 1, 2, 5, 3, 0);
    run_instr("lhu",   7'b0000011, 3'b101, 1'b0, 1'b0, 1'b0, 1, 6, 1, 0, 1, 3, 6, 4, 0);
    run_instr("sb_w1", 7'b0100011, 3'b000, 1'b0, 1'b0, 1'b0, 1, 5, 0, 2, 1, 3, 0, 0, 2);
    run_instr("sh",    7'b0100011, 3'b001, 1'b0, 1'b0, 1'b0, 0, 4, 0, 1, 1, 2, 0, 0, 1);
    run_instr("bltu_t",7'b1100011, 3'b110, 1'b0, 1'b0, 1'b1, 0, 3, 0, 0, 2, 1, 0, 0, 0);
    run_instr("bltu_n",7'b1100011, 3'b110, 1'b0, 1'b1, 1'b0, 0, 3, 0, 0, 1, 1, 0, 0, 0);
    run_instr("beq_t", 7'b1100011, 3'b000, 1'b1, 1'b0, 1'b0, 0, 3, 0, 0, 2, 1, 0, 0, 0);
    run_instr("bne_n", 7'b1100011, 3'b001, 1'b1, 1'b0, 1'b0, 0, 3, 0, 0, 1, 1, 0, 0, 0);
    run_instr("blt_n", 7'b1100011, 3'b100, 1'b0, 1'b0, 1'b1, 0, 3, 0, 0, 1, 1, 0, 0, 0);
    run_instr("bge_t", 7'b1100011, 3'b101, 1'b0, 1'b0, 1'b0, 0, 3, 0, 0, 2, 1, 0, 0, 0);
    run_instr("bgeu_t",7'b1100011, 3'b111, 1'b0, 1'b1, 1'b0, 0, 3, 0, 0, 2, 1, 0, 0, 0);
    run_instr("jal",   7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 0, 4, 1, 0, 2, 1, 4, 0, 0);
    run_instr("jalr",  7'b1100111, 3'b000, 1'b0, 1'b0, 1'b0, 0, 5, 1, 0, 2, 1, 5, 0, 0);
    run_instr("lui",   7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0, 0, 4, 1, 0, 1, 1, 4, 0, 0);
    run_instr("auipc", 7'b0010111, 3'b000, 1'b0, 1'b0, 1'b0, 0, 4, 1, 0, 1, 1, 4, 0, 0);

    // Reset in the middle of a stalled MEMREAD.
    op = 7'b0000011; funct3 = 3'b010; wait_left = 5;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #3;
      if (mem_req && adr_src) begin
        seen = 1'b1;
        break;
      end
    end
    check("memread_reached", int'(seen), 1);
    reset = 1'b1;
    hold_fetch = 1'b1;
    #1;
    check("reset_mem_req", int'(mem_req), 0);
    check("reset_mid_outputs", int'(|{pc_write, ir_write, reg_write, mem_write, adr_src,
          alu_src_a, alu_src_b, alu_op, result_src, imm_src, store, load, retire, illegal}), 0);
    wait_left = 0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    #3;
    check("post_reset_fetch_req", int'(mem_req && !adr_src && result_src == 2'b10), 1);
    check("post_reset_writes", int'(|{pc_write, ir_write, reg_write, mem_write, retire}), 0);
    hold_fetch = 1'b0;
    run_instr("add_after_reset", 7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 0, 4, 1, 0, 1, 1, 4, 0, 0);
    check("queue_empty", sb_q.size(), 0);

    // Illegal opcode, then illegal load funct3: trapping vs retiring instance.
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      #3;
      reset = 1'b1;
      op = (t == 0) ? 7'b0001111 : 7'b0000011;
      funct3 = (t == 0) ? 3'b000 : 3'b111;
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;
      n_ill = 0; n_wr = 0; n_ret = 0; nt_ret = 0; nt_ill = 0; nt_data = 0;
      for (int i = 1; i <= 10; i++) begin
        @(negedge clk);
        #3;
        n_ret   += int'(retire);
        nt_ret  += int'(nt_retire);
        nt_ill  += int'(nt_illegal);
        nt_data += int'(nt_mem_req && nt_adr_src);
        if (i >= 3) begin
          n_ill += int'(illegal);
          n_wr  += int'(pc_write | ir_write | reg_write | mem_write);
        end
      end
      check($sformatf("trap%0d_illegal_held", t), n_ill, 8);
      check($sformatf("trap%0d_no_writes", t), n_wr, 0);
      check($sformatf("trap%0d_no_retire", t), n_ret, 0);
      check($sformatf("nop%0d_retires", t), nt_ret, 5);
      check($sformatf("nop%0d_no_illegal", t), nt_ill, 0);
      check($sformatf("nop%0d_no_data_access", t), nt_data, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
